seq_shift_add_multiplier: RTL and testbench



---
 rtl/seq_shift_add_multiplier.sv | 179 +++++++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier (WIDTH x WIDTH -> 2*WIDTH) built on a block carry-lookahead adder.
// Optional early termination on the multiplier's leading one: define SEQ_MUL_EARLY_TERM_EN.

module anticipated_carry_adder #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int NB = WIDTH / BLOCK_WIDTH;

    logic [NB:0]   blk_c;
    logic [NB-1:0] blk_g;
    logic [NB-1:0] blk_p;
    logic          rip_c;

    // Block carries come from block generate/propagate; bits within a block ripple from the block carry-in.
    always_comb begin
        blk_c    = '0;
        blk_g    = '0;
        blk_p    = '0;
        sum      = '0;
        rip_c    = 1'b0;
        blk_c[0] = cin;
        for (int j = 0; j < NB; j++) begin
            blk_g[j] = 1'b0;
            blk_p[j] = 1'b1;
            for (int k = 0; k < BLOCK_WIDTH; k++) begin
                blk_g[j] = (a[j*BLOCK_WIDTH+k] & b[j*BLOCK_WIDTH+k])
                         | ((a[j*BLOCK_WIDTH+k] ^ b[j*BLOCK_WIDTH+k]) & blk_g[j]);
                blk_p[j] = blk_p[j] & (a[j*BLOCK_WIDTH+k] ^ b[j*BLOCK_WIDTH+k]);
            end
            blk_c[j+1] = blk_g[j] | (blk_p[j] & blk_c[j]);
            rip_c = blk_c[j];
            for (int k = 0; k < BLOCK_WIDTH; k++) begin
                sum[j*BLOCK_WIDTH+k] = a[j*BLOCK_WIDTH+k] ^ b[j*BLOCK_WIDTH+k] ^ rip_c;
                rip_c = (a[j*BLOCK_WIDTH+k] & b[j*BLOCK_WIDTH+k])
                      | ((a[j*BLOCK_WIDTH+k] ^ b[j*BLOCK_WIDTH+k]) & rip_c);
            end
        end
        cout = blk_c[NB];
    end
endmodule

module seq_shift_add_multiplier #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds valid/data until that edge, the consumer may raise ready at any time.
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  acc_hi;
    logic [WIDTH-1:0]  acc_lo;
    logic [CW-1:0]     counter;
    logic [WIDTH-1:0]  addend;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic [WIDTH-1:0]  acc_hi_next;
    logic [WIDTH-1:0]  acc_lo_next;
    logic [2*WIDTH-1:0] final_val;
    logic              accept;
    logic              last_step;

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;

    assign addend = acc_lo[0] ? mcand : '0;

    anticipated_carry_adder #(
        .WIDTH      (WIDTH),
        .BLOCK_WIDTH(BLOCK_WIDTH)
    ) u_adder (
        .a   (acc_hi),
        .b   (addend),
        .cin (1'b0),
        .sum (sum),
        .cout(cout)
    );

    // The adder carry lands in the MSB of acc_hi as the pair shifts right.
    assign acc_hi_next = {cout, sum[WIDTH-1:1]};
    assign acc_lo_next = {sum[0], acc_lo[WIDTH-1:1]};

`ifdef SEQ_MUL_EARLY_TERM_EN
    logic [CW-1:0] last_cnt;
    logic [CW-1:0] lead_idx;
    logic [CW-1:0] shamt;

    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) lead_idx = CW'(i);
        end
    end

    // After n steps the product sits WIDTH-n bits high in the register pair.
    assign shamt     = CW'(WIDTH - 1) - last_cnt;
    assign last_step = (counter == last_cnt);
    assign final_val = {acc_hi_next, acc_lo_next} >> shamt;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_cnt <= '0;
        end else if (accept) begin
            last_cnt <= lead_idx;
        end
    end
`else
    assign last_step = (counter == CW'(WIDTH - 1));
    assign final_val = {acc_hi_next, acc_lo_next};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            counter <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand   <= a;
                        acc_hi  <= '0;
                        acc_lo  <= b;
                        counter <= '0;
                    end
                end
                RUN: begin
                    acc_hi  <= acc_hi_next;
                    acc_lo  <= acc_lo_next;
                    counter <= counter + 1'b1;
                    if (last_step) product <= final_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier: vector table plus stall, ignored-input and mid-run reset sequences.

module tb_seq_shift_add_multiplier;
    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] product;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    seq_shift_add_multiplier #(.WIDTH(W), .BLOCK_WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .product  (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef SEQ_MUL_EARLY_TERM_EN
        int n;
        n = 1;
        for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
        return n;
`else
        return W;
`endif
    endfunction

    // Accept operands; returns at the negedge just after the accept edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_send", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Count edges from the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [2*W-1:0] exp);
        int lat;
        out_ready = 1'b1;
        send(ta, tb);
        wait_done(lat);
        check({name, "_product"}, product, exp);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat(tb)));
        @(posedge clk);
        @(negedge clk);
        check({name, "_idle_ready"}, {63'd0, in_ready}, 64'd1);
        check({name, "_valid_low"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int lat;
        n_tests = 0;
        n_fail = 0;
        vecs[0] = '{32'd3,        32'd5,        64'h000000000000000F};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080};
        vecs[3] = '{32'h0000ABCD, 32'd1,        64'h000000000000ABCD};
        vecs[4] = '{32'h00001234, 32'd0,        64'h0000000000000000};
        vecs[5] = '{32'h0000ABCD, 32'h80000000, 64'h000055E680000000};
        vecs[6] = '{32'hFFFFFFFF, 32'd1,        64'h00000000FFFFFFFF};
        vecs[7] = '{32'h00010000, 32'h00010000, 64'h0000000100000000};
        vecs[8] = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
        vecs[9] = '{32'd0,        32'hDEADBEEF, 64'h0000000000000000};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_in_ready_in_rst", {63'd0, in_ready}, 64'd0);
        check("reset_product", product, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Consumer stalls for 5 cycles in DONE.
        out_ready = 1'b0;
        send(32'h12345678, 32'h9ABCDEF0);
        wait_done(lat);
        check("stall_latency", 64'(lat), 64'(exp_lat(32'h9ABCDEF0)));
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {63'd0, out_valid}, 64'd1);
            check("stall_product", product, 64'h0B00EA4E242D2080);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            in_valid = 1'b1;
            a = 32'd1;
            b = 32'd1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stall_release_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("stall_idle_in_ready", {63'd0, in_ready}, 64'd1);
        check("stall_idle_valid", {63'd0, out_valid}, 64'd0);

        // in_valid pulsed during RUN must be ignored.
        send(32'd2, 32'd9);
        @(posedge clk);
        @(negedge clk);
        check("run_in_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1;
        a = 32'd7;
        b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        check("ignore_product", product, 64'h12);
        check("ignore_latency", 64'(lat + 2), 64'(exp_lat(32'd9)));
        @(posedge clk);
        run_op("fresh", 32'd7, 32'd7, 64'h31);

        // Reset at counter=10 discards the operation.
        send(32'h0000FFFF, 32'hFFFFFFFF);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pre_reset_valid", {63'd0, out_valid}, 64'd0);
        check("pre_reset_product", product, 64'h31);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_product", product, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (40) begin
            @(negedge clk);
            if (out_valid) check("midrst_spurious_valid", 64'd1, 64'd0);
        end
        run_op("after_rst", 32'd6, 32'd7, 64'h2A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
